// File: rtl/max_pool_2x2_if.sv
// Pixel stream bundle: frame sync, valid strobe, pixel and its column/row index.
// The master drives the stream, the slave consumes it.
interface max_pool_2x2_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  vsync;
  logic                  href;
  logic [DATA_WIDTH-1:0] data;
  logic [6:0]            h_cnt;
  logic [6:0]            v_cnt;

  modport master (
    output vsync,
    output href,
    output data,
    output h_cnt,
    output v_cnt
  );

  modport slave (
    input vsync,
    input href,
    input data,
    input h_cnt,
    input v_cnt
  );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 pooling over a raster pixel stream: max pooling by default,
// average pooling when POOL_AVG_EN is defined.
module max_pool_2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28
) (
  input  logic            clk,
  input  logic            rst_n,
  max_pool_2x2_if.slave   relu_i,
  max_pool_2x2_if.master  pool_o
);

  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
`ifdef POOL_AVG_EN
  localparam int LB_W     = DATA_WIDTH + 1;
`else
  localparam int LB_W     = DATA_WIDTH;
`endif

  logic                  vsync_q;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic                  pair_valid_q, pair_valid_d;
  logic                  armed_q, armed_d;
  logic                  pool_href_q, pool_href_d;
  logic [DATA_WIDTH-1:0] pool_data_q, pool_data_d;
  logic [6:0]            pool_h_q, pool_h_d;
  logic [6:0]            pool_v_q, pool_v_d;

  logic [LB_W-1:0]       lbuf [LB_DEPTH];
  logic [LB_W-1:0]       lb_rd_q;
  logic [LB_AW-1:0]      lb_addr;
  logic                  lb_we;
  logic                  lb_re;

  logic                  vsync_rise;
  logic                  accept;
  logic                  px_even;
  logic                  px_done;
  logic                  emit;
  logic [LB_W-1:0]       hres;
  logic [DATA_WIDTH-1:0] pool_res;
`ifdef POOL_AVG_EN
  logic [DATA_WIDTH+1:0] sum4;
`endif

  // Pixel qualification and pair/row bookkeeping
  always_comb begin
    vsync_rise = relu_i.vsync & ~vsync_q;
    accept     = relu_i.href & ({1'b0, relu_i.h_cnt} < 8'(IMG_WIDTH));
    px_even    = accept & ~relu_i.h_cnt[0];
    px_done    = accept & relu_i.h_cnt[0] & pair_valid_q & ~vsync_rise;
    lb_we      = px_done & ~relu_i.v_cnt[0];
    lb_re      = px_even & relu_i.v_cnt[0];
    emit       = px_done & relu_i.v_cnt[0] & armed_q;
    lb_addr    = relu_i.h_cnt[LB_AW:1];
  end

  // Horizontal and final reduction; the line buffer read for an odd row is
  // issued on the even pixel so it is registered by the time the pair completes.
  always_comb begin
`ifdef POOL_AVG_EN
    hres     = {1'b0, pair_q} + {1'b0, relu_i.data};
    sum4     = {1'b0, lb_rd_q} + {1'b0, hres};
    pool_res = DATA_WIDTH'(sum4 >> 2);
`else
    hres     = (pair_q >= relu_i.data) ? pair_q : relu_i.data;
    pool_res = (lb_rd_q >= hres) ? lb_rd_q : hres;
`endif
  end

  always_comb begin
    pair_d       = pair_q;
    pair_valid_d = pair_valid_q & ~vsync_rise;
    if (px_even) begin
      pair_d       = relu_i.data;
      pair_valid_d = 1'b1;
    end else if (px_done) begin
      pair_valid_d = 1'b0;
    end
    // Outputs are only trusted once an even row has been seen from column 0.
    armed_d = armed_q | (accept & (relu_i.h_cnt == 7'd0) & ~relu_i.v_cnt[0]);
  end

  always_comb begin
    pool_href_d = emit;
    pool_data_d = pool_data_q;
    pool_h_d    = pool_h_q;
    pool_v_d    = pool_v_q;
    if (emit) begin
      pool_data_d = pool_res;
      pool_h_d    = {1'b0, relu_i.h_cnt[6:1]};
      pool_v_d    = {1'b0, relu_i.v_cnt[6:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      pair_q       <= '0;
      pair_valid_q <= 1'b0;
      armed_q      <= 1'b0;
      pool_href_q  <= 1'b0;
      pool_data_q  <= '0;
      pool_h_q     <= '0;
      pool_v_q     <= '0;
    end else begin
      vsync_q      <= relu_i.vsync;
      pair_q       <= pair_d;
      pair_valid_q <= pair_valid_d;
      armed_q      <= armed_d;
      pool_href_q  <= pool_href_d;
      pool_data_q  <= pool_data_d;
      pool_h_q     <= pool_h_d;
      pool_v_q     <= pool_v_d;
    end
  end

  // Line buffer: no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lbuf[lb_addr] <= hres;
    end
    if (lb_re) begin
      lb_rd_q <= lbuf[lb_addr];
    end
  end

  assign pool_o.vsync = vsync_q;
  assign pool_o.href  = pool_href_q;
  assign pool_o.data  = pool_data_q;
  assign pool_o.h_cnt = pool_h_q;
  assign pool_o.v_cnt = pool_v_q;

endmodule
